// File: rtl/trackball_emulator.sv
`default_nettype none
// ============================================================================
// Module   : trackball_emulator
// Purpose  : Turns host mouse deltas into rate-limited 8-bit trackball counters.
// Revision : 1.0 - initial release
// ============================================================================
module trackball_emulator #(
  parameter int STEP_DIV = 8,
  parameter int MAX_PEND = 127
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce2H,
  input  logic              mouse_strobe,
  input  logic signed [8:0] mouse_dx,
  input  logic signed [8:0] mouse_dy,
  input  logic              flip,
  input  logic              TRKn,
  input  logic              BA0,
  output logic [7:0]        trk_to_cpu,
  output logic              busy
);

  localparam logic [7:0]         c_div_last = 8'(STEP_DIV - 1);
  localparam logic signed [10:0] c_max_pos  = 11'(MAX_PEND);
  localparam logic signed [10:0] c_max_neg  = 11'(-MAX_PEND);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state, w_state_next;
  logic [7:0]         r_div, w_div_next;
  logic signed [9:0]  r_pend_x, r_pend_y, w_pend_x_next, w_pend_y_next;
  logic [7:0]         r_pos_x, r_pos_y, w_pos_x_next, w_pos_y_next;
  logic               w_tick;
  logic signed [1:0]  w_adj_x, w_adj_y;
  logic [7:0]         w_step_x, w_step_y;

  function automatic logic signed [1:0] sgn(input logic signed [9:0] v);
    if (v > 10'sd0)      return 2'sb01;
    else if (v < 10'sd0) return 2'sb11;
    else                 return 2'sb00;
  endfunction

  // Tick consumption and the new delta are merged before clamping, so a
  // strobe landing on a tick loses neither event.
  function automatic logic signed [9:0] accumulate(
    input logic signed [9:0] pend,
    input logic signed [1:0] adj,
    input logic              strobe,
    input logic signed [8:0] delta
  );
    logic signed [10:0] sum;
    sum = {pend[9], pend} - {{9{adj[1]}}, adj};
    if (strobe) begin
      sum = sum + {{2{delta[8]}}, delta};
      if (sum > c_max_pos)      sum = c_max_pos;
      else if (sum < c_max_neg) sum = c_max_neg;
    end
    return sum[9:0];
  endfunction

  always_comb begin
    w_tick  = (r_state == ST_RUN) && ce2H && (r_div == c_div_last);
    w_adj_x = w_tick ? sgn(r_pend_x) : 2'sb00;
    w_adj_y = w_tick ? sgn(r_pend_y) : 2'sb00;

    w_pend_x_next = accumulate(r_pend_x, w_adj_x, mouse_strobe, mouse_dx);
    w_pend_y_next = accumulate(r_pend_y, w_adj_y, mouse_strobe, mouse_dy);

    // X "+" counts up, Y "+" counts down; flip mirrors both axes.
    w_step_x = {{6{w_adj_x[1]}}, w_adj_x};
    w_step_y = {{6{w_adj_y[1]}}, w_adj_y};
    if (flip) w_step_x = 8'd0 - w_step_x;
    else      w_step_y = 8'd0 - w_step_y;
    w_pos_x_next = r_pos_x + w_step_x;
    w_pos_y_next = r_pos_y + w_step_y;
  end

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    if ((w_pend_x_next != 10'sd0) || (w_pend_y_next != 10'sd0)) begin
      w_state_next = ST_RUN;
    end else begin
      w_state_next = ST_IDLE;
    end
    if ((r_state == ST_IDLE) || (w_state_next == ST_IDLE)) begin
      w_div_next = 8'd0;
    end else if (ce2H) begin
      w_div_next = w_tick ? 8'd0 : r_div + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_div      <= 8'd0;
      r_pend_x   <= 10'sd0;
      r_pend_y   <= 10'sd0;
      r_pos_x    <= 8'd0;
      r_pos_y    <= 8'd0;
      trk_to_cpu <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_div    <= w_div_next;
      r_pend_x <= w_pend_x_next;
      r_pend_y <= w_pend_y_next;
      r_pos_x  <= w_pos_x_next;
      r_pos_y  <= w_pos_y_next;
      if (!TRKn) trk_to_cpu <= BA0 ? r_pos_y : r_pos_x;
    end
  end

  assign busy = (r_pend_x != 10'sd0) | (r_pend_y != 10'sd0);

endmodule
`default_nettype wire

// File: tb/tb_trackball_emulator.sv
`default_nettype none
// Bench for trackball_emulator: directed scenarios plus random traffic,
// checked against an integer model of pending motion and positions.
module tb_trackball_emulator;

  localparam int STEP_DIV = 8;
  localparam int MAX_PEND = 127;

  logic              clk = 1'b0;
  logic              reset, ce2H, mouse_strobe, flip, TRKn, BA0;
  logic signed [8:0] mouse_dx, mouse_dy;
  logic [7:0]        trk_to_cpu;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_px, m_py, m_posx, m_posy, m_trk, m_pulses, m_busy;

  trackball_emulator #(.STEP_DIV(STEP_DIV), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .reset(reset), .ce2H(ce2H), .mouse_strobe(mouse_strobe),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .flip(flip), .TRKn(TRKn),
    .BA0(BA0), .trk_to_cpu(trk_to_cpu), .busy(busy)
  );

  always #50 clk = ~clk;

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int clamp(input int v);
    if (v > MAX_PEND)  return MAX_PEND;
    if (v < -MAX_PEND) return -MAX_PEND;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic cyc(input bit rst, input bit ce, input bit stb, input int dx,
                     input int dy, input bit trkn, input bit ba);
    bit run, tick;
    int ax, ay;
    reset = rst; ce2H = ce; mouse_strobe = stb;
    mouse_dx = 9'(dx); mouse_dy = 9'(dy);
    TRKn = trkn; BA0 = ba;
    @(posedge clk);
    if (rst) begin
      m_px = 0; m_py = 0; m_posx = 0; m_posy = 0; m_trk = 0; m_pulses = 0;
    end else begin
      if (!trkn) m_trk = ba ? m_posy : m_posx;
      run  = (m_px != 0) || (m_py != 0);
      tick = run && ce && (((m_pulses + 1) % STEP_DIV) == 0);
      if (tick) begin
        ax = sgn(m_px); ay = sgn(m_py);
        m_px -= ax; m_py -= ay;
        m_posx = (m_posx + (flip ? -ax : ax)) & 255;
        m_posy = (m_posy + (flip ? ay : -ay)) & 255;
      end
      if (stb) begin
        m_px = clamp(m_px + dx);
        m_py = clamp(m_py + dy);
      end
      if ((m_px == 0) && (m_py == 0)) m_pulses = 0;
      else if (run && ce)             m_pulses++;
    end
    m_busy = ((m_px != 0) || (m_py != 0)) ? 1 : 0;
    #1;
    chk("busy_model", busy, m_busy);
    chk("trk_model", trk_to_cpu, m_trk);
  endtask

  // n ce2H pulses; each pulse cycle reads Y, the following idle cycle reads X.
  task automatic run_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int dx, dy;
    flip = 1'b0;

    // Reset state and basic +3 X motion
    cyc(1, 0, 0, 0, 0, 1, 0);
    chk("rst_trk", trk_to_cpu, 8'h00);
    chk("rst_busy", busy, 1'b0);
    cyc(0, 0, 1, 3, 0, 1, 0);
    chk("t1_busy_rise", busy, 1'b1);
    run_pulses(7);
    chk("t1_px7", trk_to_cpu, 8'h00);
    run_pulses(1);
    chk("t1_px8", trk_to_cpu, 8'h01);
    run_pulses(8);
    chk("t1_px16", trk_to_cpu, 8'h02);
    run_pulses(7);
    chk("t1_busy23", busy, 1'b1);
    run_pulses(1);
    chk("t1_px24", trk_to_cpu, 8'h03);
    chk("t1_busy24", busy, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t1_py", trk_to_cpu, 8'h00);

    // Wrap-around below zero
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    run_pulses(8);
    chk("t2_pre", trk_to_cpu, 8'h01);
    cyc(0, 0, 1, -3, 0, 1, 0);
    run_pulses(8);
    chk("t2_s1", trk_to_cpu, 8'h00);
    run_pulses(8);
    chk("t2_s2", trk_to_cpu, 8'hFF);
    run_pulses(8);
    chk("t2_s3", trk_to_cpu, 8'hFE);
    chk("t2_busy", busy, 1'b0);

    // Saturation of a large Y delta
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 200, 1, 0);
    run_pulses(127 * STEP_DIV - 1);
    chk("t3_busy_before", busy, 1'b1);
    run_pulses(1);
    chk("t3_busy_after", busy, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t3_py", trk_to_cpu, 8'h81);

    // Strobe coincident with the tick that empties pend_x
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    run_pulses(7);
    cyc(0, 1, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t4_px1", trk_to_cpu, 8'h01);
    chk("t4_busy1", busy, 1'b1);
    run_pulses(7);
    chk("t4_busy_mid", busy, 1'b1);
    run_pulses(1);
    chk("t4_px2", trk_to_cpu, 8'h02);
    chk("t4_busy2", busy, 1'b0);
    run_pulses(16);
    chk("t4_px_hold", trk_to_cpu, 8'h02);

    // Flipped direction and axis-select reads
    flip = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 2, 0, 1, 0);
    run_pulses(8);
    chk("t5_px1", trk_to_cpu, 8'hFF);
    run_pulses(8);
    chk("t5_px2", trk_to_cpu, 8'hFE);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t5_rd_y", trk_to_cpu, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t5_rd_x", trk_to_cpu, 8'hFE);
    flip = 1'b0;

    // Reset mid-run discards pending motion
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 50, 0, 1, 0);
    run_pulses(40);
    chk("t6_px5", trk_to_cpu, 8'h05);
    cyc(1, 1, 1, 7, 7, 0, 0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_trk", trk_to_cpu, 8'h00);
    run_pulses(80);
    chk("t6_px_still0", trk_to_cpu, 8'h00);
    chk("t6_busy_end", busy, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) flip = ~flip;
      if ($urandom_range(0, 9) == 0) begin
        dx = int'($urandom_range(0, 511)) - 256;
        dy = int'($urandom_range(0, 511)) - 256;
      end else begin
        dx = int'($urandom_range(0, 40)) - 20;
        dy = int'($urandom_range(0, 40)) - 20;
      end
      cyc($urandom_range(0, 399) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0, dx, dy,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
